// File: rtl/gpu_pkg.sv
// gpu_pkg: definitions shared by the GPU host-port arbiter and its read-tag pipe.
//   HOST_ADDR_W : width of the GPU RAM host address
//   port_id_t   : requester identity (Z80 bus bridge / text-font fill engine)
//   rd_tag_t    : one read-pipe entry {valid, id}
package gpu_pkg;

    localparam int unsigned HOST_ADDR_W = 20;

    typedef enum logic {
        PORT_Z80  = 1'b0,
        PORT_FILL = 1'b1
    } port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t id;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_NONE = '{valid: 1'b0, id: PORT_Z80};

endpackage

// File: rtl/gpu_rd_tag_pipe.sv
// gpu_rd_tag_pipe: fixed-depth shift register of read tags. One entry is
// shifted in every clock; the entry leaving the last stage marks the cycle in
// which the matching RAM read data is present.
//   clk      : host clock
//   reset_n  : asynchronous active-low clear of every stage
//   tag_in   : tag pushed this clock (valid=0 on non-read cycles)
//   tag_out  : oldest tag, DEPTH clocks after it was pushed
module gpu_rd_tag_pipe
    import gpu_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic    clk,
    input  logic    reset_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RD_TAG_NONE;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/gpu_host_arbiter.sv
// gpu_host_arbiter: shares the single host port of the multiport GPU RAM
// between the Z80 bus bridge (port 0) and the text/font fill engine (port 1).
// Round-robin grant, optional vblank-only restriction of port 1, registered
// drive of the RAM host port and tagged read-data return.
//   clk, reset_n              : host clock, asynchronous active-low reset
//   vde_in                    : vertical display enable (synchronous to clk)
//   req/we/addr/wdata 0,1     : requester command, held until acknowledged
//   ack0, ack1                : combinational grant
//   rvalid0, rvalid1, rdata   : one-cycle read return strobe and shared data
//   ram_wr_ena/addr/wr_data   : registered RAM host port drive
//   ram_rd_data               : RAM host read data
module gpu_host_arbiter
    import gpu_pkg::*;
#(
    parameter int unsigned ADDR_W         = HOST_ADDR_W,
    parameter int unsigned RD_LATENCY     = 2,
    parameter bit          P1_VBLANK_ONLY = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vde_in,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [7:0]        wdata0,
    input  logic [7:0]        wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [7:0]        rdata,
    output logic              ram_wr_ena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wr_data,
    input  logic [7:0]        ram_rd_data
);

    port_id_t          last_q;
    logic              elig0;
    logic              elig1;
    logic              grant_z80;
    logic              grant_fill;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_wdata;
    rd_tag_t           tag_push;
    rd_tag_t           tag_pop;

    always_comb begin
        elig0 = req0;
        elig1 = req1 && !(P1_VBLANK_ONLY && vde_in);

        // Port 1 wins when it is the only candidate or when port 0 was served last.
        grant_fill = elig1 && (!elig0 || (last_q == PORT_Z80));
        grant_z80  = elig0 && !grant_fill;

        // Gating with reset_n keeps the requesters from seeing a grant that
        // the held-in-reset registers would never act on.
        ack0   = reset_n && grant_z80;
        ack1   = reset_n && grant_fill;
        accept = ack0 || ack1;

        sel_we    = ack1 ? we1    : we0;
        sel_addr  = ack1 ? addr1  : addr0;
        sel_wdata = ack1 ? wdata1 : wdata0;

        tag_push       = RD_TAG_NONE;
        tag_push.valid = accept && !sel_we;
        tag_push.id    = ack1 ? PORT_FILL : PORT_Z80;
    end

    // One extra stage over RD_LATENCY covers the ram_addr register itself, so
    // the tag leaves the pipe in the same cycle ram_rd_data becomes valid.
    gpu_rd_tag_pipe #(
        .DEPTH (RD_LATENCY + 1)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .tag_in  (tag_push),
        .tag_out (tag_pop)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q      <= PORT_Z80;
            ram_wr_ena  <= 1'b0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
        end else begin
            if (accept) begin
                last_q      <= ack1 ? PORT_FILL : PORT_Z80;
                ram_wr_ena  <= sel_we;
                ram_addr    <= sel_addr;
                ram_wr_data <= sel_wdata;
            end else begin
                ram_wr_ena  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata   <= '0;
        end else begin
            rvalid0 <= tag_pop.valid && (tag_pop.id == PORT_Z80);
            rvalid1 <= tag_pop.valid && (tag_pop.id == PORT_FILL);
            if (tag_pop.valid) begin
                rdata <= ram_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_gpu_host_arbiter.sv
// tb_gpu_host_arbiter: directed scenarios followed by randomized traffic,
// checked every cycle against a transaction-level scoreboard of the arbiter.
module tb_gpu_host_arbiter;

    localparam int unsigned AW = 20;
    localparam int unsigned L  = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          vde_in = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [7:0]    wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, rvalid0, rvalid1, ram_wr_ena;
    logic [7:0]    rdata, ram_wr_data, ram_rd_data;
    logic [AW-1:0] ram_addr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    gpu_host_arbiter #(
        .ADDR_W         (AW),
        .RD_LATENCY     (L),
        .P1_VBLANK_ONLY (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vde_in      (vde_in),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .ack0        (ack0),
        .ack1        (ack1),
        .rvalid0     (rvalid0),
        .rvalid1     (rvalid1),
        .rdata       (rdata),
        .ram_wr_ena  (ram_wr_ena),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // ---------------- RAM environment: write-first, L-clock read latency
    logic [7:0] ram_mem  [logic [AW-1:0]];
    logic [7:0] ram_pipe [L] = '{default: 8'h00};

    always @(posedge clk) begin
        logic [7:0] v;
        if (ram_wr_ena) ram_mem[ram_addr] = ram_wr_data;
        v = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : init_byte(ram_addr);
        for (int i = L - 1; i > 0; i--) ram_pipe[i] <= ram_pipe[i-1];
        ram_pipe[0] <= v;
    end
    assign ram_rd_data = ram_pipe[L-1];

    always @(posedge clk) cyc++;

    // ---------------- Reference model (transaction level)
    typedef struct {
        int         due;
        logic       id;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t       rdq[$];
    logic [7:0]    sh_mem [logic [AW-1:0]];
    logic          m_last = 1'b0;
    logic          e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [7:0]    e_wd = '0;
    logic          pend_wr = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic [7:0]    pend_data = '0;

    always @(negedge clk) begin
        logic e0, e1, g0, g1, w, x_v0, x_v1;
        logic [AW-1:0] a;
        logic [7:0] d, x_rd;
        rd_exp_t r;
        if (!reset_n) begin
            check("rst_ack0", ack0, 0);
            check("rst_ack1", ack1, 0);
            check("rst_rvalid0", rvalid0, 0);
            check("rst_rvalid1", rvalid1, 0);
            check("rst_rdata", rdata, 0);
            check("rst_wr_ena", ram_wr_ena, 0);
            check("rst_addr", ram_addr, 0);
            check("rst_wdata", ram_wr_data, 0);
            m_last = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
            pend_wr = 1'b0;
            rdq.delete();
        end else begin
            // A write reaches the RAM one edge after acceptance unless reset cut it.
            if (pend_wr) sh_mem[pend_addr] = pend_data;
            pend_wr = 1'b0;

            e0 = req0;
            e1 = req1 && !vde_in;
            if (e0 && e1) begin
                g1 = !m_last; g0 = m_last;
            end else begin
                g0 = e0; g1 = e1;
            end
            check("ack0", ack0, g0);
            check("ack1", ack1, g1);
            check("ram_wr_ena", ram_wr_ena, e_we);
            check("ram_addr", ram_addr, e_addr);
            check("ram_wr_data", ram_wr_data, e_wd);

            x_v0 = 1'b0; x_v1 = 1'b0; x_rd = 8'h00;
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                r = rdq.pop_front();
                x_v0 = !r.id; x_v1 = r.id; x_rd = r.data;
            end
            check("rvalid0", rvalid0, x_v0);
            check("rvalid1", rvalid1, x_v1);
            if (x_v0 || x_v1) check("rdata", rdata, x_rd);

            if (g0 || g1) begin
                a = g1 ? addr1 : addr0;
                w = g1 ? we1 : we0;
                d = g1 ? wdata1 : wdata0;
                m_last = g1;
                e_we = w; e_addr = a; e_wd = d;
                if (w) begin
                    pend_wr = 1'b1; pend_addr = a; pend_data = d;
                end else begin
                    r.due  = cyc + int'(L) + 2;
                    r.id   = g1;
                    r.data = sh_mem.exists(a) ? sh_mem[a] : init_byte(a);
                    rdq.push_back(r);
                end
            end else begin
                e_we = 1'b0;
            end
        end
    end

    // ---------------- Stimulus
    logic acc0 = 1'b0, acc1 = 1'b0;

    task automatic step();
        @(negedge clk);
        acc0 = req0 && ack0;
        acc1 = req1 && ack1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req0 = 1'b0; req1 = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        ram_mem[20'h01000] = 8'hA5;
        sh_mem[20'h01000]  = 8'hA5;

        // Reset with both requesting, then first tie goes to port 1.
        req0 = 1'b1; req1 = 1'b1; addr0 = 20'h00010; addr1 = 20'h00020;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        idle(6);

        // Single write.
        req0 = 1'b1; we0 = 1'b1; addr0 = 20'h00805; wdata0 = 8'h41;
        step();
        we0 = 1'b0;
        idle(3);

        // Read latency with preset RAM content.
        req0 = 1'b1; we0 = 1'b0; addr0 = 20'h01000;
        step();
        idle(6);

        // Round-robin with both held.
        req0 = 1'b1; req1 = 1'b1; we1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            addr0 = 20'h00100 + AW'(i);
            addr1 = 20'h00200 + AW'(i);
            step();
        end
        idle(8);

        // Vblank gating, then release.
        vde_in = 1'b1; req0 = 1'b1; req1 = 1'b1;
        repeat (5) step();
        vde_in = 1'b0;
        step();
        idle(8);

        // Reset with reads in flight.
        req0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr0 = 20'h00300 + AW'(i);
            step();
        end
        idle(1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        idle(8);
        req0 = 1'b1; addr0 = 20'h00805;
        step();
        idle(8);

        // Randomized traffic; small address window so writes and reads collide.
        for (int i = 0; i < 600; i++) begin
            if (!(req0 && !acc0)) begin
                req0   = ($urandom_range(0, 2) != 0);
                we0    = $urandom_range(0, 1) == 1;
                addr0  = AW'($urandom_range(0, 15));
                wdata0 = 8'($urandom);
            end
            if (!(req1 && !acc1)) begin
                req1   = ($urandom_range(0, 2) != 0);
                we1    = $urandom_range(0, 1) == 1;
                addr1  = AW'($urandom_range(0, 15));
                wdata1 = 8'($urandom);
            end
            vde_in = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) begin
                reset_n = 1'b0;
                step();
                step();
                reset_n = 1'b1;
            end
            step();
        end
        vde_in = 1'b0;
        idle(10);

        check("drain", rdq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpu_host_arbiter.md
# gpu_host_arbiter

Shares the single host port of the multiport GPU RAM between two requesters: the Z80 bus bridge (port 0) and the text/font fill engine (port 1). Round-robin arbitration, optional restriction of port 1 to vertical blanking, registered drive of the RAM host port, and tagged read-data return. Sits between the requesters and the `clk_b`/`write_ena_b`/`addr_host_in`/`data_host_in`/`data_host_out` side of `multiport_gpu_ram`.

## Interface
Parameters:
- `ADDR_W`, 20: host address width.
- `RD_LATENCY`, 2: clocks from `ram_addr` registered to valid `ram_rd_data`; legal range 1–4.
- `P1_VBLANK_ONLY`, 1: 1 = port 1 is granted only while `vde_in` is low.

Ports:
- `clk` in 1: the host clock that drives `clk_b` of the RAM. Single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `vde_in` in 1: vertical display enable, already synchronous to `clk`.
- `req0`, `req1` in 1: request; held high until accepted.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in ADDR_W: address.
- `wdata0`, `wdata1` in 8: write data.
- `ack0`, `ack1` out 1: combinational grant; a transfer happens on every cycle with `reqN && ackN`.
- `rvalid0`, `rvalid1` out 1: one-cycle read-data strobe.
- `rdata` out 8: read data, shared by both ports and qualified by `rvalidN`.
- `ram_wr_ena` out 1: goes to `write_ena_b`.
- `ram_addr` out ADDR_W: goes to `addr_host_in`.
- `ram_wr_data` out 8: goes to `data_host_in`.
- `ram_rd_data` in 8: from `data_host_out`.

## Operation
- At most one transfer is accepted per clock.
- Eligibility:
  - `elig0 = req0`.
  - `elig1 = req1 && !(P1_VBLANK_ONLY && vde_in)`.
- Arbitration uses a 1-bit `last` register, which holds the port granted most recently:
  - Only one port eligible: grant that port.
  - Both eligible: grant `!last`.
  - On every accepted transfer, `last` takes the granted port number.
- `ack0` and `ack1` are never high together. Neither is high while `reset_n` is low.
- Accepted transfer, registered into the RAM port on the next edge:
  - `ram_addr <= addr`.
  - `ram_wr_data <= wdata`.
  - `ram_wr_ena <= we`.
- Idle cycle (no acceptance): `ram_wr_ena <= 0`. `ram_addr` and `ram_wr_data` hold their previous values.
- Read tracking:
  - An accepted read pushes `{valid=1, id}` into a shift pipe `RD_LATENCY+1` entries deep.
  - All other cycles push `{0, x}`.
  - When the pipe output is valid, `rdata <= ram_rd_data` and `rvalid[id] <= 1` for one clock.
- Back-to-back reads are allowed. Returns come back in acceptance order, one per clock.
- A write followed by a read of the same address on the next cycle returns the new data. The RAM's write-first behaviour provides this; the arbiter reorders nothing.
- Reset values, all zero: `ack*`, `rvalid*`, `rdata`, `ram_wr_ena`, `ram_addr`, `ram_wr_data`, `last` (0, so port 1 wins the first tie), and every read-pipe entry.
- Reset asserted mid-operation: in-flight reads are discarded and their `rvalid` is never produced. Any write already registered is not retracted.
- `vde_in` rises while `req1` is pending: port 1 stops being eligible that same cycle. A transfer already accepted still completes.

## Timing
- Accept at edge T, meaning `req && ack` is high in the cycle ending at T.
- `ram_*` are valid in cycle T+1.
- Read data from the RAM is valid in cycle T+1+`RD_LATENCY`.
- `rvalid` and `rdata` are valid in cycle T+2+`RD_LATENCY`. With the default parameter, read latency from accept is 4 clocks.
- Write: `ram_wr_ena` is high for exactly cycle T+1.
- `ack` depends combinationally on `req*`, `vde_in` and `last` only. It does not depend on `addr`, `we` or `wdata`.
- Throughput: 1 transfer per clock.
- Fairness: with both ports continuously eligible, grants alternate 0/1 every cycle. Maximum wait for an eligible port is 1 cycle.

## Structure
- Shared package `gpu_pkg` holds:
  - `HOST_ADDR_W = 20`.
  - The port-ID constants `PORT_Z80 = 0` and `PORT_FILL = 1`.
  - The read-pipe entry typedef `{valid, id}`.
- One sub-module, `gpu_rd_tag_pipe`: a parameterised depth shift register of tag entries with asynchronous active-low clear.
- Arbitration and RAM-port registers stay in the top level.

## Test plan
- **Reset:** hold `reset_n=0` with `req0=req1=1` → `ack0=ack1=0` and all outputs 0. Release → first cycle `ack1=1` (tie, `last=0`) when `vde_in=0`.
- **Single write:** `req0`, `we0=1`, `addr0=20'h00805`, `wdata0=8'h41` → `ack0` the same cycle. Next cycle `ram_wr_ena=1`, `ram_addr=20'h00805`, `ram_wr_data=8'h41`; the cycle after, `ram_wr_ena=0`.
- **Read latency:** port 0 reads `20'h01000` with the RAM model returning `8'hA5` → `rvalid0=1`, `rdata=8'hA5` exactly 4 clocks after accept, high for 1 clock; `rvalid1` stays 0.
- **Round-robin:** `req0` and `req1` held for 6 cycles with `vde_in=0` → grants 1,0,1,0,1,0. Read returns arrive in the same order with matching `rvalid` ids.
- **Vblank gating:** `vde_in=1` with both requesting → only `ack0` for 5 cycles. Drop `vde_in` → `ack1` the same cycle.
- **Reset mid-read:** accept 3 reads, assert `reset_n=0` one cycle later, release → no `rvalid` pulses for 8 cycles, and the next new read returns normally.
